// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller: wait-cause states
// and the packed bundle of stage-register load/flush enables.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_DWAIT = 2'd1,
    HZ_IWAIT = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_load;
    logic if_id_load;
    logic id_ex_load;
    logic ex_mem_load;
    logic mem_wb_load;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_HOLD     = 7'b00000_00;
  localparam stage_ctrl_t CTRL_RUN      = 7'b11111_00;
  localparam stage_ctrl_t CTRL_REDIRECT = 7'b11111_11;
  localparam stage_ctrl_t CTRL_BUBBLE   = 7'b00111_01;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: freezes on cache misses, inserts load-use
// bubbles, flushes on EX redirects, and tracks wait cause, watchdog and perf counts.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_br_taken,
  input  logic             perf_clr,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             id_ex_load,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout,
  output logic [1:0]       state_o
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic        dwait, freeze, load_use, redirect, lu_bubble;
  stage_ctrl_t ctrl;
  hz_state_t   state_q;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  assign dwait    = dmem_req & ~dmem_resp;
  assign freeze   = dwait | ~imem_resp;
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                     (id_uses_rs2 && (ex_rd == id_rs2)));
  assign redirect  = ex_br_taken & ~freeze;
  assign lu_bubble = load_use & ~freeze & ~ex_br_taken;

  // Priority: freeze > redirect > load-use; reset keeps every stage idle.
  always_comb begin
    ctrl = CTRL_RUN;
    if (rst || freeze) begin
      ctrl = CTRL_HOLD;
    end else if (ex_br_taken) begin
      ctrl = CTRL_REDIRECT;
    end else if (load_use) begin
      ctrl = CTRL_BUBBLE;
    end
  end

  assign pc_load     = ctrl.pc_load;
  assign if_id_load  = ctrl.if_id_load;
  assign id_ex_load  = ctrl.id_ex_load;
  assign ex_mem_load = ctrl.ex_mem_load;
  assign mem_wb_load = ctrl.mem_wb_load;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_RUN;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (dwait)           state_q <= HZ_DWAIT;
          else if (!imem_resp) state_q <= HZ_IWAIT;
        end
        HZ_DWAIT: begin
          if (!dwait) state_q <= imem_resp ? HZ_RUN : HZ_IWAIT;
        end
        HZ_IWAIT: begin
          if (dwait)          state_q <= HZ_DWAIT;
          else if (imem_resp) state_q <= HZ_RUN;
        end
        default: state_q <= HZ_RUN;
      endcase
    end
  end

  // Watchdog counts consecutive frozen cycles; its count saturates so it never wraps.
  always_comb begin
    wait_cnt_d    = 16'd0;
    mem_timeout_d = mem_timeout_q;
    if (freeze) begin
      wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
      if (wait_cnt_d >= TIMEOUT_W) mem_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign state_o     = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(freeze | lu_bubble), .count(stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(lu_bubble), .count(bubble_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(redirect), .count(flush_cnt)
  );

endmodule
